// File: rtl/spike_count_readout_pkg.sv
// ---------------------------------------------------------------------------
// snn_readout_pkg
// Shared types and default sizing for the rate-coded spike-count readout.
//   readout_state_e : FSM states (IDLE, ACCUM, SCAN, DONE)
//   DEF_*           : default parameter values for the readout and its bus
//   win_width()     : bits needed to hold a window timer value 0..len
// ---------------------------------------------------------------------------
package snn_readout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } readout_state_e;

    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_WINDOW_LEN  = 64;
    localparam int DEF_IDX_W       = 4;

    function automatic int win_width(input int len);
        return $clog2(len + 1);
    endfunction

    localparam int WIN_W = win_width(DEF_WINDOW_LEN);

endpackage

// File: rtl/spike_count_readout_if.sv
// ---------------------------------------------------------------------------
// spike_count_readout_if
// Request/result bundle between the output LIF layer and the readout.
//   spike_i  : one spike bit per class
//   start_i  : request a new classification
//   busy_o   : accumulating or scanning
//   valid_o  : one-cycle pulse, result fields updated
//   class_o / count_o / tie_o / none_o : classification result
// master = the side that produces spikes and requests, slave = the readout.
// ---------------------------------------------------------------------------
interface spike_count_readout_if #(
    parameter int NUM_CLASSES = snn_readout_pkg::DEF_NUM_CLASSES,
    parameter int CNT_W       = snn_readout_pkg::DEF_CNT_W,
    parameter int IDX_W       = snn_readout_pkg::DEF_IDX_W
);
    import snn_readout_pkg::*;

    logic [NUM_CLASSES-1:0] spike_i;
    logic                   start_i;
    logic                   busy_o;
    logic                   valid_o;
    logic [IDX_W-1:0]       class_o;
    logic [CNT_W-1:0]       count_o;
    logic                   tie_o;
    logic                   none_o;

    modport master (
        output spike_i, start_i,
        input  busy_o, valid_o, class_o, count_o, tie_o, none_o
    );

    modport slave (
        input  spike_i, start_i,
        output busy_o, valid_o, class_o, count_o, tie_o, none_o
    );

endinterface

// File: rtl/spike_count_readout_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_spike_counter
// Per-class spike counter that sticks at its maximum instead of wrapping.
//   clk_i  : clock
//   rst_i  : synchronous reset, active-high
//   clr_i  : clear to zero (start of a new window)
//   inc_i  : count one spike this edge
//   cnt_o  : current count
// ---------------------------------------------------------------------------
module sat_spike_counter
    import snn_readout_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over increment; an all-ones count stays put so a very active
    // neuron cannot wrap around and lose to a quieter one.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/spike_count_readout.sv
// ---------------------------------------------------------------------------
// spike_count_readout
// Rate-coded classifier readout: counts spikes per class over WINDOW_LEN
// cycles, then scans the counts one class per cycle to find the argmax,
// reporting winner index, its count, and tie / no-spike flags.
//   clk_i : clock, rising edge
//   rst_i : synchronous reset, active-high
//   bus   : spike_count_readout_if.slave (spikes, start, busy, result)
// ---------------------------------------------------------------------------
module spike_count_readout
    import snn_readout_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WINDOW_LEN  = DEF_WINDOW_LEN,
    parameter int IDX_W       = DEF_IDX_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    spike_count_readout_if.slave bus
);

    localparam int               TMR_W     = win_width(WINDOW_LEN);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(WINDOW_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CLASSES - 1);

    readout_state_e   state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [IDX_W-1:0] scanIdx_q, scanIdx_d;
    logic [CNT_W-1:0] maxCnt_q, maxCnt_d;
    logic [IDX_W-1:0] maxIdx_q, maxIdx_d;
    logic             tieRun_q, tieRun_d;
    logic [IDX_W-1:0] class_q, class_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tie_q, tie_d;
    logic             none_q, none_d;

    logic             clrCnt;
    logic             accumEn;
    logic [CNT_W-1:0] classCnt [NUM_CLASSES];
    logic [CNT_W-1:0] selCnt;

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_counter
        sat_spike_counter #(
            .CNT_W (CNT_W)
        ) u_counter (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clrCnt),
            .inc_i (accumEn & bus.spike_i[k]),
            .cnt_o (classCnt[k])
        );
    end

    assign selCnt = classCnt[scanIdx_q];

    // Next-state and datapath control. The start edge clears the counters and
    // all scan state, so a window launched straight out of DONE begins clean.
    // During SCAN only a strictly larger count takes over the running max,
    // which makes ties resolve to the lowest index; an equal nonzero count
    // just raises the tie flag. The result registers are loaded from the
    // final scan step on the edge that enters DONE.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        scanIdx_d = scanIdx_q;
        maxCnt_d  = maxCnt_q;
        maxIdx_d  = maxIdx_q;
        tieRun_d  = tieRun_q;
        class_d   = class_q;
        count_d   = count_q;
        tie_d     = tie_q;
        none_d    = none_q;
        clrCnt    = 1'b0;
        accumEn   = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    state_d   = ACCUM;
                    clrCnt    = 1'b1;
                    timer_d   = '0;
                    scanIdx_d = '0;
                    maxCnt_d  = '0;
                    maxIdx_d  = '0;
                    tieRun_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                accumEn = 1'b1;
                timer_d = timer_q + 1'b1;
                if (timer_q == LAST_TICK) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (selCnt > maxCnt_q) begin
                    maxCnt_d = selCnt;
                    maxIdx_d = scanIdx_q;
                    tieRun_d = 1'b0;
                end else if ((selCnt == maxCnt_q) && (maxCnt_q != '0)) begin
                    tieRun_d = 1'b1;
                end
                scanIdx_d = scanIdx_q + 1'b1;
                if (scanIdx_q == LAST_IDX) begin
                    state_d = DONE;
                    class_d = maxIdx_d;
                    count_d = maxCnt_d;
                    tie_d   = tieRun_d;
                    none_d  = (maxCnt_d == '0);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q   <= '0;
            scanIdx_q <= '0;
            maxCnt_q  <= '0;
            maxIdx_q  <= '0;
            tieRun_q  <= 1'b0;
            class_q   <= '0;
            count_q   <= '0;
            tie_q     <= 1'b0;
            none_q    <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            scanIdx_q <= scanIdx_d;
            maxCnt_q  <= maxCnt_d;
            maxIdx_q  <= maxIdx_d;
            tieRun_q  <= tieRun_d;
            class_q   <= class_d;
            count_q   <= count_d;
            tie_q     <= tie_d;
            none_q    <= none_d;
        end
    end

    assign bus.busy_o  = (state_q == ACCUM) || (state_q == SCAN);
    assign bus.valid_o = (state_q == DONE);
    assign bus.class_o = class_q;
    assign bus.count_o = count_q;
    assign bus.tie_o   = tie_q;
    assign bus.none_o  = none_q;

endmodule

// File: tb/tb_spike_count_readout.sv
// ---------------------------------------------------------------------------
// tb_spike_count_readout
// Drives two readouts (8-bit and 4-bit counters, 10 classes, 16-cycle window)
// with identical spikes; checks fixed vectors, reset abort, back-to-back
// windows and random windows against an argmax reference model.
// ---------------------------------------------------------------------------
module tb_spike_count_readout;

    localparam int NCLS    = 10;
    localparam int WIN     = 16;
    localparam int LATENCY = WIN + NCLS;

    logic clk;
    logic rst;
    int   cycleCnt;
    int   compared;
    int   mismatched;

    logic [NCLS-1:0] stim [WIN];

    spike_count_readout_if #(.NUM_CLASSES(NCLS), .CNT_W(8), .IDX_W(4)) bus1 ();
    spike_count_readout_if #(.NUM_CLASSES(NCLS), .CNT_W(4), .IDX_W(4)) bus2 ();

    assign bus2.spike_i = bus1.spike_i;
    assign bus2.start_i = bus1.start_i;

    spike_count_readout #(
        .NUM_CLASSES (NCLS),
        .CNT_W       (8),
        .WINDOW_LEN  (WIN),
        .IDX_W       (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    spike_count_readout #(
        .NUM_CLASSES (NCLS),
        .CNT_W       (4),
        .WINDOW_LEN  (WIN),
        .IDX_W       (4)
    ) dutSmall (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Argmax over saturated per-class spike totals of the current window.
    function automatic void refModel(input int satMax, output int cls, output int cnt,
                                     output int tie, output int none);
        int c [NCLS];
        int maxV;
        int hits;
        for (int k = 0; k < NCLS; k++) c[k] = 0;
        for (int i = 0; i < WIN; i++)
            for (int k = 0; k < NCLS; k++)
                if (stim[i][k]) c[k]++;
        for (int k = 0; k < NCLS; k++)
            if (c[k] > satMax) c[k] = satMax;
        maxV = 0;
        cls  = 0;
        for (int k = 0; k < NCLS; k++)
            if (c[k] > maxV) begin
                maxV = c[k];
                cls  = k;
            end
        hits = 0;
        for (int k = 0; k < NCLS; k++)
            if (c[k] == maxV) hits++;
        cnt  = maxV;
        none = (maxV == 0) ? 1 : 0;
        tie  = (maxV != 0 && hits > 1) ? 1 : 0;
    endfunction

    // Called just after a falling edge. Start edge E0, stim[i] sampled on
    // E(i+1), junk spikes elsewhere; returns at the falling edge where valid
    // is seen (or the cycle budget runs out), lat = edges since E0.
    task automatic applyStimulus(input bit midStart, output int lat, output bit got);
        bus1.start_i = 1'b1;
        bus1.spike_i = NCLS'($urandom);
        @(posedge clk);
        lat = 0;
        for (int i = 0; i < WIN; i++) begin
            @(negedge clk);
            bus1.start_i = midStart && (i == 5);
            bus1.spike_i = stim[i];
            @(posedge clk);
            lat++;
        end
        @(negedge clk);
        bus1.start_i = 1'b0;
        bus1.spike_i = NCLS'($urandom);
        while (!bus1.valid_o && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus1.spike_i = NCLS'($urandom);
        end
        got = bus1.valid_o;
    endtask

    task automatic checkWindow(input string tag, input int lat, input bit got,
                               input int cls, input int cnt, input int tieE, input int noneE,
                               input int clsS, input int cntS, input int tieS, input int noneS);
        checkOutput({tag, ".validSeen"}, int'(got), 1);
        checkOutput({tag, ".latency"}, lat, LATENCY);
        checkOutput({tag, ".validSmall"}, int'(bus2.valid_o), 1);
        checkOutput({tag, ".class"}, int'(bus1.class_o), cls);
        checkOutput({tag, ".count"}, int'(bus1.count_o), cnt);
        checkOutput({tag, ".tie"}, int'(bus1.tie_o), tieE);
        checkOutput({tag, ".none"}, int'(bus1.none_o), noneE);
        checkOutput({tag, ".classSmall"}, int'(bus2.class_o), clsS);
        checkOutput({tag, ".countSmall"}, int'(bus2.count_o), cntS);
        checkOutput({tag, ".tieSmall"}, int'(bus2.tie_o), tieS);
        checkOutput({tag, ".noneSmall"}, int'(bus2.none_o), noneS);
    endtask

    typedef struct {
        logic [NCLS-1:0] maskA;
        logic [NCLS-1:0] maskB;
        bit              midStart;
        int              expClass;
        int              expCount;
        int              expCountSmall;
        int              expTie;
        int              expNone;
    } vec_t;

    initial begin
        vec_t vecs [7];
        int   lat;
        bit   got;
        int   firstValid;
        int   secondValid;
        bit   seen;
        int   mc, mn, mt, mz;
        int   sc, sn, st, sz;
        int   mode;

        // maskA drives even window cycles, maskB odd ones (8 each)
        vecs[0] = '{10'h008, 10'h008, 1'b0, 3, 16, 15, 0, 0};
        vecs[1] = '{10'h000, 10'h000, 1'b0, 0,  0,  0, 0, 1};
        vecs[2] = '{10'h084, 10'h000, 1'b0, 2,  8,  8, 1, 0};
        vecs[3] = '{10'h012, 10'h010, 1'b0, 4, 16, 15, 0, 0};
        vecs[4] = '{10'h200, 10'h001, 1'b0, 0,  8,  8, 1, 0};
        vecs[5] = '{10'h3FF, 10'h040, 1'b0, 6, 16, 15, 0, 0};
        vecs[6] = '{10'h020, 10'h020, 1'b1, 5, 16, 15, 0, 0};

        compared     = 0;
        mismatched   = 0;
        rst          = 1'b1;
        bus1.start_i = 1'b0;
        bus1.spike_i = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", int'(bus1.busy_o), 0);
        checkOutput("reset.valid", int'(bus1.valid_o), 0);
        checkOutput("reset.class", int'(bus1.class_o), 0);
        checkOutput("reset.count", int'(bus1.count_o), 0);
        checkOutput("reset.tie", int'(bus1.tie_o), 0);
        checkOutput("reset.none", int'(bus1.none_o), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < WIN; i++)
                stim[i] = (i % 2 == 0) ? vecs[v].maskA : vecs[v].maskB;
            applyStimulus(vecs[v].midStart, lat, got);
            checkWindow($sformatf("vec%0d", v), lat, got,
                        vecs[v].expClass, vecs[v].expCount, vecs[v].expTie, vecs[v].expNone,
                        vecs[v].expClass, vecs[v].expCountSmall, vecs[v].expTie, vecs[v].expNone);
            @(negedge clk);
            @(negedge clk);
            checkOutput($sformatf("vec%0d.validDropped", v), int'(bus1.valid_o), 0);
            checkOutput($sformatf("vec%0d.classHeld", v), int'(bus1.class_o), vecs[v].expClass);
            checkOutput($sformatf("vec%0d.countHeld", v), int'(bus1.count_o), vecs[v].expCount);
        end

        // Back-to-back: start held into DONE, so the DONE cycle is the next
        // start edge and valid pulses are WIN+NCLS+1 edges apart.
        for (int i = 0; i < WIN; i++) stim[i] = 10'h008;
        applyStimulus(1'b0, lat, got);
        firstValid = cycleCnt;
        checkWindow("b2bFirst", lat, got, 3, 16, 0, 0, 3, 15, 0, 0);
        for (int i = 0; i < WIN; i++) stim[i] = NCLS'($urandom);
        refModel(255, mc, mn, mt, mz);
        refModel(15, sc, sn, st, sz);
        applyStimulus(1'b0, lat, got);
        secondValid = cycleCnt;
        checkWindow("b2bSecond", lat, got, mc, mn, mt, mz, sc, sn, st, sz);
        checkOutput("b2b.validGap", secondValid - firstValid, LATENCY + 1);

        // Reset in the middle of accumulation aborts the window.
        @(negedge clk);
        bus1.start_i = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus1.start_i = 1'b0;
            bus1.spike_i = 10'h008;
            @(posedge clk);
        end
        @(negedge clk);
        checkOutput("abort.busyBefore", int'(bus1.busy_o), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort.busy", int'(bus1.busy_o), 0);
        checkOutput("abort.valid", int'(bus1.valid_o), 0);
        checkOutput("abort.count", int'(bus1.count_o), 0);
        checkOutput("abort.none", int'(bus1.none_o), 0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus1.valid_o) seen = 1'b1;
        end
        checkOutput("abort.noValid", int'(seen), 0);
        for (int i = 0; i < WIN; i++) stim[i] = 10'h008;
        applyStimulus(1'b0, lat, got);
        checkWindow("restart", lat, got, 3, 16, 0, 0, 3, 15, 0, 0);

        // Random windows of varying spike density, random idle gaps.
        for (int r = 0; r < 20; r++) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < WIN; i++) begin
                if (mode == 0)
                    stim[i] = NCLS'($urandom & $urandom & $urandom);
                else if (mode == 1)
                    stim[i] = NCLS'($urandom);
                else
                    stim[i] = NCLS'($urandom | $urandom);
            end
            refModel(255, mc, mn, mt, mz);
            refModel(15, sc, sn, st, sz);
            applyStimulus(1'b0, lat, got);
            checkWindow($sformatf("rand%0d", r), lat, got, mc, mn, mt, mz, sc, sn, st, sz);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
